// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and helpers for the FIFO write-port arbiter.
//            Contents:
//              - arb_state_t : arbiter state (IDLE / LOCK)
//              - clog2()     : ceiling log2, never returns less than 1
//              - STATS_W     : width of the optional statistics counters
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int STATS_W = 16;

    // Ceiling log2. The result is at least 1 so that it can always size a
    // vector, including for a value of 1 or 2.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating priority encoder. It returns the first
//            set bit of req, scanning start, start+1, ... and wrapping
//            modulo N.
// Ports    : req   in  N  request vector
//            start in  W  scan start index (must be < N)
//            any   out 1  at least one request bit is set
//            idx   out W  selected index; equals start when any=0
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] idx
);

    int w_j;

    always_comb begin
        any = 1'b0;
        idx = start;
        w_j = 0;
        for (int k = 0; k < N; k++) begin
            // The candidate index is reduced modulo N explicitly, so a
            // non-power-of-two N never yields an out-of-range index.
            w_j = int'(start) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!any && req[w_j]) begin
                any = 1'b1;
                idx = W'(w_j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter that shares one FIFO write port between
//            NUM_REQ valid/ready producers. A packet lock keeps the grant on
//            one producer until its req_last beat, or until MAX_BURST beats
//            have gone through, so that packets never interleave.
// Ports    : clk, reset (synchronous, active high)
//            req_valid/req_last/req_data  producer side
//            req_ready                    one-hot or zero accept strobe
//            fifo_full                    FIFO back-pressure
//            fifo_wr/fifo_wdata           FIFO write side
//            grant_id                     currently selected requester
//            locked                       packet lock held
// Option   : FIFO_WR_ARBITER_STATS_EN adds stats_clr (in), stall_cnt and
//            word_cnt (out, STATS_W bits each).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 8,
    localparam int ID_W       = clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [ID_W-1:0]               grant_id,
    output logic                          locked
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [STATS_W-1:0]            stall_cnt,
    output logic [STATS_W-1:0]            word_cnt
`endif
);

    localparam int CNT_W   = clog2(MAX_BURST + 1);
    localparam bit LOCK_EN = (MAX_BURST > 1);

    arb_state_t             r_state,    w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr,   w_rr_ptr_nxt;
    logic [ID_W-1:0]        r_owner,    w_owner_nxt;
    logic [CNT_W-1:0]       r_beat_cnt, w_beat_cnt_nxt;

    logic                   w_pick_any;
    logic [ID_W-1:0]        w_pick_idx;
    logic [ID_W-1:0]        w_sel;
    logic [ID_W-1:0]        w_sel_next;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_xfer;
    logic [CNT_W-1:0]       w_beat_inc;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (r_rr_ptr),
        .any   (w_pick_any),
        .idx   (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // Selection, data mux and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = (r_state == LOCK) ? r_owner : w_pick_idx;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        w_xfer     = w_sel_valid & ~fifo_full & ((r_state == LOCK) | w_pick_any);
        w_sel_next = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        w_beat_inc = r_beat_cnt + 1'b1;

        // Outputs are held at their idle values while reset is asserted.
        fifo_wr    = w_xfer & ~reset;
        fifo_wdata = w_sel_data;
        grant_id   = reset ? '0 : w_sel;
        locked     = (r_state == LOCK) & ~reset;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == ID_W'(i)) begin
                req_ready[i] = fifo_wr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Without a transfer nothing moves, which also
    // freezes the lock and beat count while the FIFO is full.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        if (w_xfer) begin
            case (r_state)
                IDLE: begin
                    if (w_sel_last || !LOCK_EN) begin
                        w_rr_ptr_nxt = w_sel_next;
                    end else begin
                        w_state_nxt    = LOCK;
                        w_owner_nxt    = w_sel;
                        w_beat_cnt_nxt = CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (w_sel_last || (w_beat_inc == CNT_W'(MAX_BURST))) begin
                        w_state_nxt    = IDLE;
                        w_rr_ptr_nxt   = w_sel_next;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = w_beat_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: stall cycles saturate, accepted words wrap.
    // ------------------------------------------------------------------
    logic [STATS_W-1:0] r_stall_cnt;
    logic [STATS_W-1:0] r_word_cnt;

    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            r_stall_cnt <= '0;
            r_word_cnt  <= '0;
        end else begin
            if ((|req_valid) && fifo_full && (r_stall_cnt != {STATS_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_xfer) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign word_cnt  = r_word_cnt;
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter (NUM_REQ=4,
//            DATA_WIDTH=8, MAX_BURST=8). Directed vector table plus
//            hand-written burst, reset-in-lock and statistics sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    logic        locked;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic        stats_clr;
    logic [15:0] stall_cnt;
    logic [15:0] word_cnt;
`endif

    int n_checks;
    int n_fail;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .locked     (locked)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .stall_cnt  (stall_cnt),
        .word_cnt   (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic       exp_wr;
        logic [3:0] exp_ready;
        logic [1:0] exp_grant;
        logic       exp_locked;
        logic [7:0] exp_wdata;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic wr, input logic [3:0] ready,
                              input logic [1:0] grant, input logic lck, input logic [7:0] wdata);
        check({name, ".fifo_wr"},   32'(fifo_wr),   32'(wr));
        check({name, ".req_ready"}, 32'(req_ready), 32'(ready));
        check({name, ".grant_id"},  32'(grant_id),  32'(grant));
        check({name, ".locked"},    32'(locked),    32'(lck));
        if (wr) begin
            check({name, ".fifo_wdata"}, 32'(fifo_wdata), 32'(wdata));
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        fifo_full = 1'b0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef FIFO_WR_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif

        //           valid    last     full  wr    ready    grant  lock  wdata
        tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h11};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 8'h22};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, 8'h33};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0, 8'h44};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h11};
        tbl[5]  = '{4'b0111, 4'b0111, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 8'h22};
        // requester 2: 3-beat packet while 0 and 1 stay valid
        tbl[6]  = '{4'b0111, 4'b0011, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, 8'h33};
        tbl[7]  = '{4'b0111, 4'b0011, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
        tbl[8]  = '{4'b0111, 4'b0111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
        // 3 not valid, so the pointer wraps to 0
        tbl[9]  = '{4'b0011, 4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h11};
        // requester 1 opens a packet, then 5 full cycles mid-packet
        tbl[10] = '{4'b0011, 4'b0000, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0, 8'h22};
        tbl[11] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00};
        tbl[12] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00};
        tbl[13] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00};
        tbl[14] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00};
        tbl[15] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00};
        tbl[16] = '{4'b0011, 4'b0000, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22};
        tbl[17] = '{4'b0011, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22};
        // idle with nothing valid shows rr_ptr; full in idle stalls everyone
        tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};
        tbl[19] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};
        tbl[20] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0, 8'h33};
        // owner 0 drops valid while locked: others stay stalled
        tbl[21] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 8'h11};
        tbl[22] = '{4'b1110, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h00};
        tbl[23] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11};

        // Outputs during reset
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outs("in_reset", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);

        // Reset state: idle, pointer at 0
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        #1;
        check_outs("after_reset", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].valid, tbl[i].last, tbl[i].full);
            check_outs($sformatf("vec%0d", i), tbl[i].exp_wr, tbl[i].exp_ready,
                       tbl[i].exp_grant, tbl[i].exp_locked, tbl[i].exp_wdata);
        end

        // MAX_BURST: requester 1 streams without last (pointer is 1 here).
        // Two full cycles after beat 4 must not advance the beat count.
        for (int b = 1; b <= 8; b++) begin
            if (b == 5) begin
                for (int s = 0; s < 2; s++) begin
                    drive(4'b1111, 4'b1101, 1'b1);
                    check_outs("burst_full", 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00);
                end
            end
            drive(4'b1111, 4'b1101, 1'b0);
            check_outs($sformatf("burst_beat%0d", b), 1'b1, 4'b0010, 2'd1, (b > 1), 8'h22);
        end
        drive(4'b1111, 4'b1101, 1'b0);
        check_outs("burst_next2", 1'b1, 4'b0100, 2'd2, 1'b0, 8'h33);
        drive(4'b1111, 4'b1101, 1'b0);
        check_outs("burst_next3", 1'b1, 4'b1000, 2'd3, 1'b0, 8'h44);
        drive(4'b1111, 4'b1101, 1'b0);
        check_outs("burst_next0", 1'b1, 4'b0001, 2'd0, 1'b0, 8'h11);
        drive(4'b1111, 4'b1101, 1'b0);
        check_outs("burst_beat9", 1'b1, 4'b0010, 2'd1, 1'b0, 8'h22);
        drive(4'b1111, 4'b1111, 1'b0);
        check_outs("burst_beat10", 1'b1, 4'b0010, 2'd1, 1'b1, 8'h22);

        // Reset while locked with beat_cnt=4 (pointer is 2 here)
        for (int b = 1; b <= 4; b++) begin
            drive(4'b0100, 4'b0000, 1'b0);
            check_outs($sformatf("rlock_beat%0d", b), 1'b1, 4'b0100, 2'd2, (b > 1), 8'h33);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("rlock_in_reset", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b0000;
        #1;
        check_outs("rlock_post_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
        drive(4'b1010, 4'b1010, 1'b0);
        check_outs("rlock_first_grant", 1'b1, 4'b0010, 2'd1, 1'b0, 8'h22);

`ifdef FIFO_WR_ARBITER_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        req_valid = 4'b0000;
        fifo_full = 1'b0;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        check("stats_start_word",  32'(word_cnt),  32'd0);
        check("stats_start_stall", 32'(stall_cnt), 32'd0);
        for (int k = 0; k < 7; k++) begin
            drive(4'b0001, 4'b0001, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 4'b0001, 1'b1);
        end
        drive(4'b0000, 4'b0000, 1'b0);
        check("stats_word7",  32'(word_cnt),  32'd7);
        check("stats_stall3", 32'(stall_cnt), 32'd3);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        check("stats_clr_word",  32'(word_cnt),  32'd0);
        check("stats_clr_stall", 32'(stall_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
